// File: rtl/u712_dma_cycle.sv
// Chip RAM DMA cycle tracker: follows the asynchronous Agnus strobes, requests an SDRAM slot
// once a column strobe shows up, and holds the lane strobes and direction steady for the
// byte enable block until the cycle ends.
module u712_dma_cycle (
    input  logic clk80_i,
    input  logic nreset_i,
    input  logic nras_i,
    input  logic ncasu_i,
    input  logic ncasl_i,
    input  logic ndben_i,
    input  logic anwe_i,
    input  logic dma_ack_i,
    output logic dma_cycle_o,
    output logic dma_ncasu_o,
    output logic dma_ncasl_o,
    output logic dma_ndben_o,
    output logic dma_rnw_o,
    output logic dma_req_o
);

    typedef enum logic [2:0] {StIdle, StRas, StCas, StReq, StDone} state_e;

    // Bundled strobes: {nras, ncasu, ncasl, ndben, anwe}
    logic [4:0] sync1_q, sync2_q;
    logic       nras_s, ncasu_s, ncasl_s, ndben_s, anwe_s;

    // flush_q[1] goes high once stage 2 holds a real pin sample instead of its reset value
    logic [1:0] flush_q;
    logic       armed_q, armed_d;
    logic [3:0] cnt_q, cnt_d;
    state_e     state_q, state_d;
    // Latched {ncasu, ncasl, ndben, rnw}
    logic [3:0] lanes_q, lanes_d;

    assign {nras_s, ncasu_s, ncasl_s, ndben_s, anwe_s} = sync2_q;

    // Two-flop synchronizers, idle-high on reset
    always_ff @(posedge clk80_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
            flush_q <= '0;
        end else begin
            sync1_q <= {nras_i, ncasu_i, ncasl_i, ndben_i, anwe_i};
            sync2_q <= sync1_q;
            flush_q <= {flush_q[0], 1'b1};
        end
    end

    // Next-state logic for the cycle FSM, arming flag, RAS wait counter and lane latches
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        lanes_d = lanes_q;

        // Only arm on a genuine high nRAS so a cycle already in flight at reset is skipped
        if (flush_q[1] && nras_s) begin
            armed_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (armed_q && !nras_s) begin
                    state_d = StRas;
                    cnt_d   = 4'd0;
                end
            end
            StRas: begin
                if (!ncasu_s || !ncasl_s) begin
                    state_d = StCas;
                    lanes_d = {ncasu_s, ncasl_s, ndben_s, anwe_s};
                end else if (nras_s) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd15) begin
                    // Timed out with nRAS still low: wait for nRAS high before re-entering
                    state_d = StIdle;
                    armed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCas: begin
                // Late-arriving lanes join the active set (active-low, so AND)
                state_d      = StReq;
                lanes_d[3:1] = lanes_q[3:1] & {ncasu_s, ncasl_s, ndben_s};
            end
            StReq: begin
                if (dma_ack_i) begin
                    state_d = StDone;
                end else if (nras_s) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (nras_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            lanes_d = '1;
        end
    end

    // State registers
    always_ff @(posedge clk80_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            armed_q <= 1'b0;
            lanes_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            lanes_q <= lanes_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once
    always_comb begin
        dma_cycle_o = (state_q == StCas) || (state_q == StReq) || (state_q == StDone);
        dma_req_o   = (state_q == StReq);
        {dma_ncasu_o, dma_ncasl_o, dma_ndben_o, dma_rnw_o} = lanes_q;
    end

endmodule

// File: tb/tb_u712_dma_cycle.sv
// Vector bench for u712_dma_cycle: one row per clock, inputs driven on the falling edge,
// outputs after the next rising edge compared on the following falling edge.
module tb_u712_dma_cycle;

    logic clk = 1'b0;
    logic nreset, nras, ncasu, ncasl, ndben, anwe, dma_ack;
    logic dma_cycle, dma_ncasu, dma_ncasl, dma_ndben, dma_rnw, dma_req;

    always #5 clk = ~clk;

    u712_dma_cycle dut (
        .clk80_i    (clk),
        .nreset_i   (nreset),
        .nras_i     (nras),
        .ncasu_i    (ncasu),
        .ncasl_i    (ncasl),
        .ndben_i    (ndben),
        .anwe_i     (anwe),
        .dma_ack_i  (dma_ack),
        .dma_cycle_o(dma_cycle),
        .dma_ncasu_o(dma_ncasu),
        .dma_ncasl_o(dma_ncasl),
        .dma_ndben_o(dma_ndben),
        .dma_rnw_o  (dma_rnw),
        .dma_req_o  (dma_req)
    );

    // in  = {nras, ncasu, ncasl, ndben, anwe}
    // exp = {dma_cycle, dma_req, dma_ncasu, dma_ncasl, dma_ndben, dma_rnw}
    typedef struct {
        bit       rst;
        bit [4:0] in;
        bit       ack;
        bit [5:0] exp;
    } vec_t;

    localparam bit [5:0] IdleOut = 6'b00_1111;
    localparam bit [4:0] InIdle  = 5'b11111;
    localparam bit [4:0] InRas   = 5'b01111;
    localparam bit [4:0] InRead  = 5'b00011;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic v(input bit rst, input bit [4:0] in, input bit ack, input bit [5:0] exp);
        vec_t r;
        r.rst = rst;
        r.in  = in;
        r.ack = ack;
        r.exp = exp;
        vecs.push_back(r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) v(1, InIdle, 0, IdleOut);
    endtask

    task automatic ras_rows(input int n, input bit [4:0] in);
        for (int i = 0; i < n; i++) v(1, in, 0, IdleOut);
    endtask

    // Read, both lanes: RAS after 3rd edge, CAS strobes from the 4th, ACK two clocks into REQ
    task automatic seq_read();
        ras_rows(3, InRas);
        ras_rows(2, InRead);
        v(1, InRead, 0, 6'b10_0011);
        v(1, InRead, 0, 6'b11_0011);
        v(1, InRead, 0, 6'b11_0011);
        v(1, InRead, 1, 6'b10_0011);
        v(1, InIdle, 0, 6'b10_0011);
        v(1, InIdle, 0, 6'b10_0011);
        v(1, InIdle, 0, IdleOut);
    endtask

    task automatic check(input int idx, input string name, input bit [5:0] exp);
        bit [5:0] act;
        act = {dma_cycle, dma_req, dma_ncasu, dma_ncasl, dma_ndben, dma_rnw};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %b want %b (cyc,req,ncasu,ncasl,ndben,rnw)",
                     name, idx, act, exp);
        end
    endtask

    initial begin
        nreset  = 1'b0;
        {nras, ncasu, ncasl, ndben, anwe} = InIdle;
        dma_ack = 1'b0;

        // Reset, then arm with nRAS high
        v(0, InIdle, 0, IdleOut);
        v(0, InIdle, 0, IdleOut);
        idle(4);

        // Read cycle
        seq_read();
        idle(1);

        // Write, lower lane only; ACK outside REQ must do nothing
        for (int i = 0; i < 3; i++) v(1, InRas, 1, IdleOut);
        ras_rows(2, 5'b01000);
        v(1, 5'b01000, 0, 6'b10_1000);
        v(1, 5'b01000, 0, 6'b11_1000);
        v(1, 5'b01000, 1, 6'b10_1000);
        v(1, InIdle, 0, 6'b10_1000);
        v(1, InIdle, 0, 6'b10_1000);
        v(1, InIdle, 0, IdleOut);
        idle(1);

        // Lane merge: lower lane first, upper lane one clock later
        ras_rows(3, InRas);
        v(1, 5'b01011, 0, IdleOut);
        v(1, InRead, 0, IdleOut);
        v(1, InRead, 0, 6'b10_1011);
        v(1, InRead, 0, 6'b11_0011);
        v(1, InRead, 1, 6'b10_0011);
        v(1, InIdle, 0, 6'b10_0011);
        v(1, InIdle, 0, 6'b10_0011);
        v(1, InIdle, 0, IdleOut);
        idle(1);

        // RAS-only refresh, 10 clocks
        ras_rows(10, InRas);
        idle(3);

        // Timeout: CAS seen only after the counter expired, no re-entry while nRAS stays low
        ras_rows(18, InRas);
        ras_rows(7, InRead);
        idle(3);

        // CAS seen one clock before the timeout still makes a cycle; then abort by nRAS high
        ras_rows(15, InRas);
        ras_rows(2, InRead);
        v(1, InRead, 0, 6'b10_0011);
        v(1, InRead, 0, 6'b11_0011);
        v(1, InIdle, 0, 6'b11_0011);
        v(1, InIdle, 0, 6'b11_0011);
        v(1, InIdle, 0, IdleOut);
        idle(1);

        // ACK in the same cycle nRAS_S rises: DONE, then IDLE
        ras_rows(3, InRas);
        ras_rows(2, InRead);
        v(1, InRead, 0, 6'b10_0011);
        v(1, InRead, 0, 6'b11_0011);
        v(1, InIdle, 0, 6'b11_0011);
        v(1, InIdle, 0, 6'b11_0011);
        v(1, InIdle, 1, 6'b10_0011);
        v(1, InIdle, 0, IdleOut);
        idle(1);

        // Reset released with nRAS low: no cycle until nRAS goes high then low again
        v(0, InRas, 0, IdleOut);
        v(0, InRas, 0, IdleOut);
        ras_rows(2, InRas);
        ras_rows(6, InRead);
        idle(3);
        seq_read();
        idle(1);

        // Reset pulsed during REQ
        ras_rows(3, InRas);
        ras_rows(2, InRead);
        v(1, InRead, 0, 6'b10_0011);
        v(1, InRead, 0, 6'b11_0011);
        v(0, InRead, 0, IdleOut);
        idle(4);
        seq_read();
        idle(2);

        @(negedge clk);
        foreach (vecs[i]) begin
            nreset  = vecs[i].rst;
            {nras, ncasu, ncasl, ndben, anwe} = vecs[i].in;
            dma_ack = vecs[i].ack;
            if (!vecs[i].rst) begin
                #1;
                check(i, "async_rst", vecs[i].exp);
            end
            @(negedge clk);
            check(i, "vec", vecs[i].exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/u712_dma_cycle.md
U712_DMA_CYCLE -- requirements
Module: U712_DMA_CYCLE

Interface
REQ-001 CLK80  input  1  system clock; all state on rising edge.
REQ-002 nRESET  input  1  asynchronous, active-low reset.
REQ-003 nRAS  input  1  Agnus chip RAM row strobe, asynchronous to CLK80.
REQ-004 nCASU, nCASL  input  1 each  Agnus upper/lower byte column strobes, asynchronous.
REQ-005 nDBEN  input  1  Agnus data bus enable (word select), asynchronous.
REQ-006 AnWE  input  1  Agnus write strobe, active-low, asynchronous.
REQ-007 DMA_ACK  input  1  SDRAM controller accepted the DMA request; sampled high.
REQ-008 DMA_CYCLE  output  1  chip RAM DMA cycle active; steers the byte enable block.
REQ-009 DMA_nCASU, DMA_nCASL, DMA_nDBEN  output  1 each  latched Agnus lane strobes for the byte enable block.
REQ-010 DMA_RnW  output  1  latched direction; 1 = Agnus read of chip RAM.
REQ-011 DMA_REQ  output  1  request to SDRAM controller.

Function
REQ-012 nRAS, nCASU, nCASL, nDBEN, AnWE SHALL each pass a two-flop synchronizer; only stage-2 outputs (_S) are used by logic.
REQ-013 State machine SHALL have states IDLE, RAS, CAS, REQ, DONE.
REQ-014 An ARMED flag SHALL clear on reset and set on first cycle nRAS_S = 1; IDLE SHALL not leave while ARMED = 0 (no entry mid-cycle after reset).
REQ-015 IDLE -> RAS when ARMED = 1 and nRAS_S = 0; nRAS low at edge k SHALL yield state RAS after edge k+2.
REQ-016 RAS -> CAS when nCASU_S = 0 or nCASL_S = 0.
REQ-017 RAS -> IDLE when nRAS_S = 1 (RAS-only refresh) or a 4-bit wait counter, cleared on RAS entry, reaches 15; no request issued.
REQ-018 On the RAS -> CAS transition, DMA_nCASU, DMA_nCASL, DMA_nDBEN SHALL load from the _S values and DMA_RnW SHALL load AnWE_S.
REQ-019 CAS -> REQ unconditionally after one cycle (lane settle); during CAS a lane whose _S goes low SHALL be OR-ed in (active-low AND).
REQ-020 DMA_REQ SHALL be 1 exactly in REQ; REQ -> DONE when DMA_ACK = 1.
REQ-021 REQ -> IDLE with DMA_REQ dropped if nRAS_S = 1 and DMA_ACK = 0 (abort); DMA_ACK = 1 with nRAS_S = 1 in same cycle SHALL take DONE.
REQ-022 DONE -> IDLE when nRAS_S = 1; otherwise hold.
REQ-023 DMA_CYCLE SHALL be 1 in CAS, REQ, DONE, and 0 in IDLE and RAS.
REQ-024 Latched lane/direction outputs SHALL stay constant from CAS entry until IDLE entry, then return to 1.
REQ-025 DMA_ACK outside REQ SHALL be ignored.

Reset
REQ-026 nRESET low SHALL immediately force IDLE, ARMED = 0, counter = 0, synchronizers to 1, DMA_CYCLE = 0, DMA_REQ = 0, DMA_nCASU = DMA_nCASL = DMA_nDBEN = DMA_RnW = 1.
REQ-027 Reset asserted in any state, including REQ, SHALL drop DMA_REQ without waiting for DMA_ACK.

Verification
REQ-028 Read cycle: nRAS low, 3 clocks later nCASU = nCASL = 0, nDBEN = 1, AnWE = 1, ACK 2 clocks after REQ -> DMA_CYCLE = 1, DMA_nCASU = DMA_nCASL = 0, DMA_nDBEN = 1, DMA_RnW = 1, one REQ episode, IDLE after nRAS high + 2 clocks.
REQ-029 Write, lower lane only: nCASL = 0, nCASU = 1, nDBEN = 0, AnWE = 0 -> DMA_nCASU = 1, DMA_nCASL = 0, DMA_nDBEN = 0, DMA_RnW = 0.
REQ-030 RAS-only refresh: nRAS low 10 clocks, no CAS -> DMA_CYCLE and DMA_REQ stay 0; also nRAS low 20 clocks -> timeout to IDLE at 15, no re-entry until nRAS high.
REQ-031 Abort: nRAS high while in REQ, ACK never -> DMA_REQ falls, IDLE, latched outputs = 1; simultaneous ACK and nRAS high -> DONE then IDLE.
REQ-032 Reset released with nRAS held low -> stays IDLE until nRAS high then low again.
REQ-033 nRESET pulsed low during REQ -> DMA_REQ and DMA_CYCLE 0 asynchronously, all outputs at reset values.
